// File: rtl/port_arbiter_4.sv
// Four-way round-robin arbiter for one shared datapath port.
// One-hot registered grant, mux select, dead cycle between owners.
module port_arbiter_4 #(
  parameter int MAX_HOLD = 4,
  parameter int CW       = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN  = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW:0]   HOLD    = (CW+1)'(MAX_HOLD);

  logic [1:0]    state;
  logic [1:0]    last;
  logic [1:0]    win;
  logic [1:0]    idx;
  logic [CW-1:0] cnt;
  logic [CW:0]   cnt_inc;
  logic          others;
  logic          cap_hit;
  logic          rel;

  // Winner: first request after the previous owner, previous owner last.
  always_comb begin
    win = last;
    idx = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) win = idx;
    end
  end

  // Release decision for the current owner (owner index is sel).
  always_comb begin
    cnt_inc = {1'b0, cnt} + 1'b1;
    cap_hit = (cnt_inc >= HOLD);
    others  = |(req & ~grant);
    rel     = !req[sel] || (done && cap_hit && others);
  end

  // Ownership state, grant, select, pointer and transaction count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= 4'b0000;
      sel   <= 2'd0;
      last  <= 2'd3;
      cnt   <= '0;
    end else begin
      case (state)
        OWN: begin
          if (done && cnt != CNT_MAX) cnt <= cnt + 1'b1;
          if (rel) begin
            state <= GAP;
            grant <= 4'b0000;
            last  <= sel;
          end
        end
        default: begin
          if (|req) begin
            state <= OWN;
            grant <= 4'b0001 << win;
            sel   <= win;
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy = |grant;

endmodule

// File: tb/tb_port_arbiter_4.sv
// Directed bench for port_arbiter_4 with a behavioural scoreboard.
// Two instances share stimulus: MAX_HOLD=4 and MAX_HOLD=1.
module tb_port_arbiter_4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [3:0] g0, g1;
  logic [1:0] s0, s1;
  logic       b0, b1;

  int tests = 0;
  int fails = 0;

  port_arbiter_4 #(.MAX_HOLD(4), .CW(3)) u_dut0 (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant(g0), .sel(s0), .busy(b0)
  );

  port_arbiter_4 #(.MAX_HOLD(1), .CW(3)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant(g1), .sel(s1), .busy(b1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [3:0] act,
                     input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: owner index or -1, pointer, completed count.
  int m_owner[2];
  int m_last[2];
  int m_cnt[2];
  int m_sel[2];
  int m_mh[2] = '{4, 1};

  function automatic int pick(input int lst, input logic [3:0] r);
    for (int off = 1; off <= 4; off++)
      if (r[(lst + off) % 4]) return (lst + off) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] exp_grant(input int k);
    return (m_owner[k] >= 0) ? 4'(1 << m_owner[k]) : 4'b0000;
  endfunction

  // Model update on each edge, same reset behaviour as the block.
  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_owner[k] = -1;
        m_last[k]  = 3;
        m_cnt[k]   = 0;
        m_sel[k]   = 0;
      end else if (m_owner[k] >= 0) begin
        int o;
        bit comp;
        o = m_owner[k];
        comp = 1'b0;
        for (int j = 0; j < 4; j++)
          if (j != o && req[j]) comp = 1'b1;
        if (done && m_cnt[k] < 7) m_cnt[k]++;
        if (!req[o] || (done && m_cnt[k] >= m_mh[k] && comp)) begin
          m_last[k]  = o;
          m_owner[k] = -1;
        end
      end else if (req != 4'b0000) begin
        m_owner[k] = pick(m_last[k], req);
        m_sel[k]   = m_owner[k];
        m_cnt[k]   = 0;
      end
    end
  end

  // Cycle-by-cycle compare of both instances against the model.
  always @(negedge clk) begin
    chk("m0_grant", g0, exp_grant(0));
    chk("m0_sel", {2'b00, s0}, 4'(m_sel[0]));
    chk("m0_busy", {3'b000, b0}, {3'b000, exp_grant(0) != 0});
    chk("m1_grant", g1, exp_grant(1));
    chk("m1_sel", {2'b00, s1}, 4'(m_sel[1]));
    chk("m1_busy", {3'b000, b1}, {3'b000, exp_grant(1) != 0});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    step();
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] seq[5];
    logic [3:0] sels[5];
    logic [3:0] exp_seq[5];
    logic [3:0] exp_sel[5];
    logic [3:0] prevg;
    int n;
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_sel = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};

    // Reset then single request
    reset_dut();
    chk("rst_grant", g0, 4'b0000);
    chk("rst_sel", {2'b00, s0}, 4'd0);
    chk("rst_busy", {3'b000, b0}, 4'd0);
    req = 4'b0100;
    step();
    chk("single_grant", g0, 4'b0100);
    chk("single_sel", {2'b00, s0}, 4'd2);
    chk("single_busy", {3'b000, b0}, 4'd1);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("single_hold0", g0, 4'b0100);
    chk("single_hold1", g1, 4'b0100);
    step();
    chk("single_hold2", g0, 4'b0100);
    req = 4'b0000;
    step();
    chk("single_rel", g0, 4'b0000);
    step();

    // Rotation with MAX_HOLD=1 on the second instance
    reset_dut();
    req   = 4'b1111;
    done  = 1'b1;
    n     = 0;
    prevg = 4'b0000;
    for (int c = 0; c < 40 && n < 5; c++) begin
      step();
      if (g1 != 4'b0000 && prevg == 4'b0000) begin
        seq[n]  = g1;
        sels[n] = {2'b00, s1};
        n++;
      end
      prevg = g1;
    end
    chk("rot_count", 4'(n), 4'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < n) begin
        chk("rot_grant", seq[i], exp_seq[i]);
        chk("rot_sel", sels[i], exp_sel[i]);
      end
    end
    done = 1'b0;

    // Fairness cap with MAX_HOLD=4
    reset_dut();
    req = 4'b0010;
    step();
    chk("cap_own1", g0, 4'b0010);
    req  = 4'b1010;
    done = 1'b1;
    step();
    chk("cap_d1", g0, 4'b0010);
    step();
    chk("cap_d2", g0, 4'b0010);
    step();
    chk("cap_d3", g0, 4'b0010);
    step();
    chk("cap_rel", g0, 4'b0000);
    step();
    chk("cap_next", g0, 4'b1000);
    chk("cap_next_sel", {2'b00, s0}, 4'd3);
    done = 1'b0;
    req  = 4'b0000;
    step();

    // Abandon
    reset_dut();
    req = 4'b0001;
    step();
    chk("ab_own0", g0, 4'b0001);
    req = 4'b0000;
    step();
    chk("ab_rel", g0, 4'b0000);
    req = 4'b0011;
    step();
    chk("ab_next", g0, 4'b0010);
    req = 4'b0000;
    step();

    // Simultaneous done and request drop, then done while idle
    reset_dut();
    req = 4'b0100;
    step();
    chk("sim_own", g0, 4'b0100);
    req  = 4'b0000;
    done = 1'b1;
    step();
    done = 1'b0;
    chk("sim_rel", g0, 4'b0000);
    step();
    chk("sim_idle", g0, 4'b0000);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("idle_done", g0, 4'b0000);
    chk("idle_sel", {2'b00, s0}, 4'd2);
    step();

    // Asynchronous reset mid-grant
    reset_dut();
    req = 4'b0010;
    step();
    chk("ar_own", g0, 4'b0010);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_grant", g0, 4'b0000);
    chk("ar_busy", {3'b000, b0}, 4'd0);
    chk("ar_sel", {2'b00, s0}, 4'd0);
    step();
    #2;
    rst = 1'b0;
    req = 4'b1111;
    step();
    chk("ar_first", g0, 4'b0001);
    req = 4'b0000;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/port_arbiter_4.md
# port_arbiter_4

Round-robin arbiter/scheduler that shares one datapath resource (memory port, register-file write port) among four requesters. Drives the `sel` input of the 4-to-1 select mux in front of that resource and issues a one-hot grant. Inserts a one-cycle dead cycle between owners so the mux select never changes under an active grant. Holds a grant across back-to-back transactions, with a fairness cap.

## Interface
Parameters:
- `MAX_HOLD`, 4: maximum completed transactions per grant while another requester is waiting; legal range 1 to 2^CW-1.
- `CW`, 3: width of the transaction counter.

Ports:
- `clk`  input  1  clock, all state changes on the rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `req`  input  4  request per requester; bit i is requester i. Held high while requester i wants the resource.
- `done`  input  1  one-cycle pulse from the resource: the current transaction has completed.
- `grant`  output  4  one-hot grant, registered; all zero when no owner.
- `sel`  output  2  binary index of the current or last owner; feeds the mux select.
- `busy`  output  1  resource owned; equals OR of `grant`.

## Operation
- State register has three states:
  - `IDLE`: no owner.
  - `OWN`: `grant[owner]` = 1.
  - `GAP`: one dead cycle after release.
- Round-robin pointer `last` holds the index of the previous owner; reset value is 3, so requester 0 has first priority after reset.
- Winner selection: the first asserted `req` bit scanning `last+1`, `last+2`, `last+3`, `last`, modulo 4. The previous owner therefore has lowest priority.
- `IDLE`:
  - If `req` != 0, go to `OWN` with winner w, set `grant` = 1<<w, set `sel` = w, clear `cnt` to 0.
  - Otherwise stay in `IDLE`.
- `OWN` (owner o):
  - `done` = 1: if `cnt` < 2^CW-1, `cnt` <= `cnt`+1, otherwise it saturates.
    - Release to `GAP` if `req[o]` = 0.
    - Also release to `GAP` if `cnt`+1 >= `MAX_HOLD` and any other `req` bit is high.
    - Otherwise stay in `OWN`. This covers back-to-back transactions and the case where no competitor is waiting, so the cap does not apply.
  - `done` = 0 and `req[o]` = 0: abandon; release to `GAP`.
  - Otherwise stay in `OWN`.
  - Release actions: `grant` <= 0, `last` <= o, `sel` unchanged.
- `GAP`:
  - If `req` != 0, go to `OWN` with a new winner computed using the updated `last`.
  - Otherwise go to `IDLE`.
  - `sel` keeps the last owner index until a new grant is issued.
- `done` outside `OWN` is ignored.
- Changes to non-owner `req` bits never affect the current owner.
- `done` and `req[o]` falling in the same cycle produce exactly one release, with `cnt` irrelevant.

## Timing
- Reset values of all outputs:
  - `grant` = 4'b0000, `sel` = 2'b00, `busy` = 0.
  - Internal: state = `IDLE`, `last` = 3, `cnt` = 0.
- Reset asserted mid-`OWN` clears `grant` and `busy` immediately, asynchronously, without waiting for an edge.
- Grant latency: `req` sampled high at edge N in `IDLE` gives `grant`/`busy` high after edge N, i.e. in cycle N+1.
- Release latency:
  - Release condition sampled at edge N: `grant` = 0 in cycle N+1 (`GAP`).
  - Next owner's grant appears in cycle N+2 at the earliest.
  - Minimum dead time between different or same owners is therefore exactly one cycle.
- `sel` changes only on the edge that enters `OWN`, so it is stable for the entire duration of a grant.
- All outputs are registered; there is no combinational path from `req` or `done` to any output.

## Test plan
- Reset then single request:
  - Stimulus: `req` = 4'b0100 from cycle 2, with `done` pulsed at cycle 6.
  - Required: `grant` = 4'b0100, `sel` = 2 and `busy` = 1 from cycle 3.
  - Required: `grant` stays held after the `done` pulse because `req[2]` is still high and no other requester is waiting.
- Rotation:
  - Stimulus: `req` = 4'b1111 held, `MAX_HOLD` = 1, `done` every cycle while owned.
  - Required: grant order 0, 1, 2, 3, 0 with one zero-grant `GAP` cycle between each owner.
  - Required: `sel` sequence 0, 1, 2, 3, 0, changing only when a new grant appears.
- Fairness cap:
  - Stimulus: `MAX_HOLD` = 4; requester 1 owns; `req[3]` rises; `done` pulses every cycle.
  - Required: requester 1 releases after its 4th `done`, then `GAP`, then `grant` = 4'b1000.
- Abandon:
  - Stimulus: requester 0 owns, `req[0]` drops with no `done`.
  - Required: `grant` = 0 the next cycle; with `req[0]` = 1 again and `req[1]` = 1, requester 1 wins next.
- Simultaneous events:
  - Stimulus: `done` and `req[o]` fall in the same cycle.
  - Required: single release and one `GAP` cycle; `done` pulses while in `IDLE` produce no state change.
- Asynchronous reset mid-grant:
  - Stimulus: assert `rst` between edges while `grant` = 4'b0010.
  - Required: `grant` = 0, `busy` = 0 and `sel` = 0 immediately.
  - Required: after release of `rst`, `req` = 4'b1111 grants requester 0 first.
